// File: rtl/mag_cmp_stream_if.sv
// Operand/result handshake bundle for the streaming magnitude comparator.
// The producer side drives operands and consumes results (master); the
// comparator sits on the slave modport.
interface mag_cmp_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       result;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, signed_mode, in_valid, out_ready,
    input  in_ready, result, out_valid
  );

  modport slave (
    input  a, b, signed_mode, in_valid, out_ready,
    output in_ready, result, out_valid
  );
endinterface

// File: rtl/mag_cmp_stream.sv
// Streaming magnitude comparator with a one-entry output register and
// saturating per-outcome event counters. Result code: 2'b10 a>b,
// 2'b01 b>a, 2'b00 equal.
module mag_cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  mag_cmp_stream_if.slave  bus,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [1:0] result_reg;
  logic [1:0] result_next;

  logic       accept;
  logic       consume;
  logic       a_gt_b;
  logic       a_lt_b;
  logic [1:0] code;
  logic [2:0] hit;   // [0] a>b, [1] b>a, [2] equal

  // Inverting the sign bit maps two's-complement ordering onto unsigned
  // ordering, so one unsigned comparator serves both modes.
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  assign a_key = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
  assign b_key = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};

  assign a_gt_b = (a_key > b_key);
  assign a_lt_b = (a_key < b_key);
  assign code   = a_gt_b ? 2'b10 : (a_lt_b ? 2'b01 : 2'b00);
  assign hit    = {~a_gt_b & ~a_lt_b, a_lt_b, a_gt_b};

  assign bus.out_valid = (state_reg == ST_FULL);
  assign bus.in_ready  = (state_reg == ST_EMPTY) | bus.out_ready;
  assign bus.result    = result_reg;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

  // Output-slot FSM and result load: a new pair always refills the slot,
  // a consume without a new pair empties it.
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    if (accept) begin
      state_next  = ST_FULL;
      result_next = code;
    end else if (consume) begin
      state_next = ST_EMPTY;
    end
  end

  // Register the output slot; reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      result_reg <= 2'b00;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
    end
  end

  // One saturating counter per outcome; clr zeroes it unless the same
  // cycle's accepted pair lands in it, in which case it restarts at one.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Count accepted pairs whose outcome matches this counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (clr) begin
        cnt_reg <= (accept && hit[gi]) ? CNT_ONE : '0;
      end else if (accept && hit[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign gt_cnt = g_cnt[0].cnt_reg;
  assign lt_cnt = g_cnt[1].cnt_reg;
  assign eq_cnt = g_cnt[2].cnt_reg;

endmodule
